// File: rtl/morse_receiver.sv
// Morse code receiver: oversamples a keyed line, classifies marks as dot/dash
// and decodes the letters S..Z into the board's 3-bit letter code.
module morse_receiver #(
  parameter int SAMPLE_CYCLES = 6250000,
  parameter int SPU           = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_in,
  output logic [2:0] letter,
  output logic       valid,
  output logic       error,
  output logic       busy
);

  localparam int DIV_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int RUN_W = $clog2(5 * SPU + 1);

  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SAMPLE_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_SAT  = RUN_W'(5 * SPU);
  localparam logic [RUN_W-1:0] DASH_MIN = RUN_W'(2 * SPU);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MARK  = 2'd1;
  localparam logic [1:0] SPACE = 2'd2;
  localparam logic [1:0] STUCK = 2'd3;

  logic             key_m;
  logic             key_s;
  logic [DIV_W-1:0] div_cnt;
  logic             samp;
  logic [1:0]       state;
  logic [RUN_W-1:0] run_len;
  logic [3:0]       elem;
  logic [2:0]       elem_cnt;
  logic             overflow;
  logic             dec_ok;
  logic [2:0]       dec_code;

  always_ff @(posedge clk) begin
    if (!reset) begin
      key_m <= 1'b0;
      key_s <= 1'b0;
    end else begin
      key_m <= key_in;
      key_s <= key_m;
    end
  end

  // samp is registered so the first strobe lands SAMPLE_CYCLES cycles after reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= DIV_LOAD;
      samp    <= 1'b0;
    end else begin
      samp    <= (div_cnt == '0);
      div_cnt <= (div_cnt == '0) ? DIV_LOAD : div_cnt - 1'b1;
    end
  end

  always_comb begin
    dec_ok   = 1'b0;
    dec_code = 3'b000;
    if (!overflow) begin
      case (elem_cnt)
        3'd1: if (elem[0]) begin dec_ok = 1'b1; dec_code = 3'b001; end
        3'd3: begin
          case (elem[2:0])
            3'b000:  begin dec_ok = 1'b1; dec_code = 3'b000; end
            3'b100:  begin dec_ok = 1'b1; dec_code = 3'b010; end
            3'b110:  begin dec_ok = 1'b1; dec_code = 3'b100; end
            default: ;
          endcase
        end
        3'd4: begin
          case (elem)
            4'b1000: begin dec_ok = 1'b1; dec_code = 3'b011; end
            4'b1001: begin dec_ok = 1'b1; dec_code = 3'b101; end
            4'b1101: begin dec_ok = 1'b1; dec_code = 3'b110; end
            4'b0011: begin dec_ok = 1'b1; dec_code = 3'b111; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      run_len  <= '0;
      elem     <= 4'b0000;
      elem_cnt <= 3'd0;
      overflow <= 1'b0;
      letter   <= 3'b000;
      valid    <= 1'b0;
      error    <= 1'b0;
    end else begin
      valid <= 1'b0;
      error <= 1'b0;
      if (samp) begin
        case (state)
          IDLE: begin
            if (key_s) begin
              state   <= MARK;
              run_len <= RUN_ONE;
            end
          end
          MARK: begin
            if (key_s) begin
              run_len <= (run_len == RUN_SAT) ? RUN_SAT : run_len + RUN_ONE;
              if (run_len == RUN_SAT - RUN_ONE) begin
                error <= 1'b1;
                state <= STUCK;
              end
            end else begin
              if (elem_cnt < 3'd4) begin
                elem[elem_cnt[1:0]] <= (run_len >= DASH_MIN);
                elem_cnt            <= elem_cnt + 3'd1;
              end else begin
                overflow <= 1'b1;
              end
              state   <= SPACE;
              run_len <= RUN_ONE;
            end
          end
          SPACE: begin
            if (key_s) begin
              state   <= MARK;
              run_len <= RUN_ONE;
            end else begin
              run_len <= run_len + RUN_ONE;
              // a gap of 2*SPU samples closes the letter
              if (run_len == DASH_MIN - RUN_ONE) begin
                if (dec_ok) begin
                  letter <= dec_code;
                  valid  <= 1'b1;
                end else begin
                  error <= 1'b1;
                end
                elem     <= 4'b0000;
                elem_cnt <= 3'd0;
                overflow <= 1'b0;
                state    <= IDLE;
              end
            end
          end
          STUCK: begin
            if (!key_s) begin
              elem     <= 4'b0000;
              elem_cnt <= 3'd0;
              overflow <= 1'b0;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_morse_receiver.sv
// Bench for morse_receiver: directed letters plus random element sequences
// scored against a string-based letter table model.
module tb_morse_receiver;

  localparam int SC  = 4;
  localparam int SPU = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_in = 1'b0;
  logic [2:0] letter;
  logic       valid;
  logic       error;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int valid_seen = 0;
  int error_seen = 0;
  int both_seen = 0;
  logic [2:0] exp_letter = 3'b000;
  int mark_len[16];
  int gap_len[16];
  int n_marks;
  string table_s[8];

  morse_receiver #(.SAMPLE_CYCLES(SC), .SPU(SPU)) dut (
    .clk(clk), .reset(reset), .key_in(key_in),
    .letter(letter), .valid(valid), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) valid_seen++;
    if (error) error_seen++;
    if (valid && error) both_seen++;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic holdSamples(input logic level, input int n);
    key_in = level;
    repeat (n * SC) @(negedge clk);
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      holdSamples(1'b1, mark_len[i]);
      holdSamples(1'b0, gap_len[i]);
    end
    holdSamples(1'b0, 2);
  endtask

  // Reference: marks >= 2*SPU are dashes, gaps >= 2*SPU end a letter,
  // and the collected dot/dash string is looked up in the letter table.
  task automatic modelExpect(input int n, output int ev, output int ee);
    string s;
    int found;
    s  = "";
    ev = 0;
    ee = 0;
    for (int i = 0; i < n; i++) begin
      if (mark_len[i] >= 2 * SPU) s = {s, "-"};
      else                        s = {s, "."};
      if (gap_len[i] >= 2 * SPU) begin
        found = -1;
        for (int k = 0; k < 8; k++) if (table_s[k] == s) found = k;
        if (found >= 0) begin
          ev++;
          exp_letter = found[2:0];
        end else begin
          ee++;
        end
        s = "";
      end
    end
  endtask

  task automatic loadPattern(input string p);
    n_marks = p.len();
    for (int i = 0; i < n_marks; i++) begin
      mark_len[i] = (p.getc(i) == "-") ? 12 : 4;
      gap_len[i]  = 4;
    end
    gap_len[n_marks-1] = 12;
  endtask

  task automatic runLetters(input string tag);
    int v0, e0, ev, ee;
    v0 = valid_seen;
    e0 = error_seen;
    modelExpect(n_marks, ev, ee);
    applyStimulus(n_marks);
    checkOutput({tag, " valid"}, valid_seen - v0, ev);
    checkOutput({tag, " error"}, error_seen - e0, ee);
    checkOutput({tag, " letter"}, {29'd0, letter}, {29'd0, exp_letter});
    checkOutput({tag, " busy"}, {31'd0, busy}, 0);
  endtask

  initial begin
    int v0, e0;
    string p;
    table_s[0] = "...";  table_s[1] = "-";    table_s[2] = "..-";  table_s[3] = "...-";
    table_s[4] = ".--";  table_s[5] = "-..-"; table_s[6] = "-.--"; table_s[7] = "--..";

    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("reset letter", {29'd0, letter}, 0);
    checkOutput("reset valid", {31'd0, valid}, 0);
    checkOutput("reset error", {31'd0, error}, 0);
    checkOutput("reset busy", {31'd0, busy}, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    loadPattern("...");  runLetters("S");
    loadPattern("-.--"); runLetters("Y");
    loadPattern(".-");   runLetters("unknown");
    loadPattern("-");    runLetters("T");

    v0 = valid_seen;
    e0 = error_seen;
    holdSamples(1'b1, 24);
    checkOutput("stuck error", error_seen - e0, 1);
    checkOutput("stuck busy", {31'd0, busy}, 1);
    holdSamples(1'b0, 12);
    checkOutput("stuck release busy", {31'd0, busy}, 0);
    checkOutput("stuck release error", error_seen - e0, 1);
    checkOutput("stuck valid", valid_seen - v0, 0);
    loadPattern("...");   runLetters("S after stuck");
    loadPattern("....."); runLetters("overflow");

    v0 = valid_seen;
    e0 = error_seen;
    holdSamples(1'b1, 4); holdSamples(1'b0, 4);
    holdSamples(1'b1, 4); holdSamples(1'b0, 2);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    exp_letter = 3'b000;
    checkOutput("midreset letter", {29'd0, letter}, 0);
    checkOutput("midreset busy", {31'd0, busy}, 0);
    checkOutput("midreset pulses", (valid_seen - v0) + (error_seen - e0), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    loadPattern("--.."); runLetters("Z");

    n_marks = 3;
    mark_len[0] = 4; gap_len[0] = 7;
    mark_len[1] = 4; gap_len[1] = 7;
    mark_len[2] = 4; gap_len[2] = 12;
    runLetters("gap7 S");
    n_marks = 2;
    mark_len[0] = 12; gap_len[0] = 8;
    mark_len[1] = 12; gap_len[1] = 12;
    runLetters("gap8 split");
    n_marks = 1; mark_len[0] = 8; gap_len[0] = 12;
    runLetters("mark8 dash");
    n_marks = 1; mark_len[0] = 7; gap_len[0] = 12;
    runLetters("mark7 dot");

    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 1) == 1) begin
        p = table_s[$urandom_range(0, 7)];
      end else begin
        p = "";
        for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
          if ($urandom_range(0, 1) == 1) p = {p, "-"};
          else                           p = {p, "."};
        end
      end
      n_marks = p.len();
      for (int i = 0; i < n_marks; i++) begin
        mark_len[i] = (p.getc(i) == "-") ? int'($urandom_range(8, 19)) : int'($urandom_range(1, 7));
        gap_len[i]  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 10)) : int'($urandom_range(1, 7));
      end
      gap_len[n_marks-1] = $urandom_range(8, 14);
      runLetters("random");
    end

    checkOutput("valid/error overlap", both_seen, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/morse_receiver.md
Name: morse_receiver

Overview:
- Decodes Morse code keyed on a single input line back into the 3-bit letter code used by the board's Morse transmitter.
- Covers the eight letters S, T, U, V, W, X, Y, Z, codes 3'b000..3'b111.
- Oversamples the key, measures mark and space run lengths in sample units, and classifies each mark as dot or dash.
- Matches the element sequence against the letter table and pulses valid or error at each letter boundary.
- Sits between a debounced KEY/GPIO input and display logic (HEX/LEDR).

Parameters:
- SAMPLE_CYCLES, 6250000, clk cycles between sample strobes (4 samples per 0.5 s unit at 50 MHz).
- SPU, 4, samples per Morse unit. Must be >=2.

Ports:
- clk  input  1  system clock (50 MHz on board)
- reset  input  1  synchronous active-low reset
- key_in  input  1  raw key level, 1 = tone/on; asynchronous to clk
- letter  output  3  last successfully decoded letter code
- valid  output  1  one-cycle pulse: letter updated
- error  output  1  one-cycle pulse: malformed letter discarded
- busy  output  1  1 while a letter is in progress (state != IDLE)

Behaviour:
- Reset: reset is synchronous, active-low; clock is clk. On reset: letter=0, valid=0, error=0, busy=0, state=IDLE, all counters and element buffer cleared.
- Input conditioning: key_in passes through a 2-flop synchronizer. Only the synchronized value (key_s) is used.
- Sample strobe: a divider counts SAMPLE_CYCLES-1 down to 0 and pulses samp for one clk. The first samp occurs SAMPLE_CYCLES cycles after reset deasserts. All FSM decisions happen only on samp cycles.
- Run counter: run_len counts consecutive samples at the same level. It resets to 1 on a level change and saturates at 5*SPU.
- Element buffer: elem[3:0] with elem[i] = i-th element sent (0 = dot, 1 = dash), plus elem_cnt (0..4) and an overflow flag.
- FSM, evaluated on samp:
  - IDLE: key_s=1 -> MARK, run_len=1. Otherwise stay.
  - MARK, key_s=1: run_len++. If run_len reaches 5*SPU -> error pulse, go to STUCK.
  - MARK, key_s=0: classify the mark just ended. run_len < 2*SPU is a dot; otherwise a dash. If elem_cnt<4, store at index elem_cnt and increment; else set overflow. Then go to SPACE with run_len=1.
  - SPACE, key_s=1: inter-element gap. Go to MARK, run_len=1.
  - SPACE, key_s=0: run_len++. When run_len reaches 2*SPU, the letter ends: decode, pulse valid or error, clear buffer and overflow, go to IDLE.
  - STUCK: wait for key_s=0 on a samp, then clear the buffer and go to IDLE. No pulse is issued on exit.
- Decode table (elements in send order): S=dot dot dot ->000; T=dash ->001; U=dot dot dash ->010; V=dot dot dot dash ->011; W=dot dash dash ->100; X=dash dot dot dash ->101; Y=dash dot dash dash ->110; Z=dash dash dot dot ->111.
- Any other sequence, or overflow set -> error, and letter is unchanged.
- Output timing: valid/error assert on the clk cycle after the deciding samp and last exactly one cycle. valid and error are never asserted together.
- letter holds its value until the next valid.
- Reset mid-letter: partial letter discarded, no pulse.
- Boundary: a mark of exactly 2*SPU samples is a dash. A space of 2*SPU-1 samples is still an inter-element gap.

Test Plan (SAMPLE_CYCLES=4, SPU=4, 1 unit = 16 clk; key driven aligned to units):
- S: on1 off1 on1 off1 on1, then off3 -> one valid pulse, letter=3'b000, error never high, busy=0 afterwards.
- Y: on3 off1 on1 off1 on3 off1 on3, then off3 -> valid, letter=3'b110. Repeat with T (on3 off3) -> letter=3'b001.
- Unknown sequence dot dash (on1 off1 on3 off3) -> error pulse once, valid stays 0, letter keeps the previous value (3'b110).
- Stuck key: key high 6 units -> error pulse when the mark reaches 20 samples, busy stays 1 until key release; after release a valid S decodes normally.
- Overflow: five dots then off3 -> error pulse only.
- Reset pulse mid-letter after two dots -> no valid/error; outputs are zero; the next full Z (on3 off1 on3 off1 on1 off1 on1 off3) -> letter=3'b111.
- Boundary: space of 7 samples between dots keeps one letter; 8 samples splits it (two T's from on3, off 2 units, on3, off3 -> two valid pulses, letter=3'b001).
